command_controller_rw: RTL and testbench
========================================

Name: command_controller_rw

Overview:
- Parametrised successor to the byte-stream command controller.
- Parses an 8-bit byte stream (i_data/i_dv) into register-bank write and read transactions, with configurable address and data widths and a programmable write-enable pulse length.
- Adds a read path that returns register data as a byte stream with a valid/ready handshake, an inter-byte timeout, and error reporting.
- Sits between the UART receiver/transmitter and the register bank.

Parameters:
- ADDR_BYTES, 1, address length in bytes (1..4); o_w_addr/o_r_addr width = 8*ADDR_BYTES.
- DATA_BYTES, 4, data length in bytes (1..8); data width = 8*DATA_BYTES.
- PULSE_W_EN_LEN, 1, cycles o_w_en stays high per write (>=1).
- TIMEOUT_CYCLES, 1000, idle cycles allowed between bytes of one transaction; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous reset, active-low
- i_data  in  8  received byte
- i_dv  in  1  i_data valid, one-cycle strobe per byte
- o_w_addr  out  8*ADDR_BYTES  write address
- o_w_data  out  8*DATA_BYTES  write data
- o_w_en  out  1  write enable pulse
- o_r_addr  out  8*ADDR_BYTES  read address
- o_r_en  out  1  read request, one-cycle pulse
- i_r_data  in  8*DATA_BYTES  read data
- i_r_valid  in  1  i_r_data valid, one-cycle strobe
- o_tx_data  out  8  response byte
- o_tx_dv  out  1  response byte valid
- i_tx_ready  in  1  transmitter accepts o_tx_data when o_tx_dv && i_tx_ready
- o_err  out  1  one-cycle error pulse
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_reset==0 at a clk edge): all outputs go to 0, FSM goes to IDLE, counters clear. Reset takes effect mid-transaction: partial data is discarded and no write is issued.
- Commands: 0x01 = WRITE, 0x02 = READ. Any other byte received in IDLE drives o_err high for one cycle and the FSM stays in IDLE.
- Byte order: multi-byte fields are received and sent MSB first. Example: bytes 01 23 34 56 give data 0x01233456.
- FSM states: IDLE, ADDR, WDATA, WPULSE, RREQ, RWAIT, TX.
- IDLE: WRITE -> ADDR (write flag set); READ -> ADDR (read flag set).
- ADDR: shifts in ADDR_BYTES bytes. On the last byte: write -> WDATA; read -> RREQ.
- WDATA: shifts in DATA_BYTES bytes. On the last byte's dv edge (cycle N):
  - o_w_addr and o_w_data update at N+1 and hold until the next write.
  - o_w_en is high for cycles N+1 .. N+PULSE_W_EN_LEN.
  - FSM is in WPULSE during the pulse, then returns to IDLE.
- RREQ: o_r_addr updates and o_r_en pulses for exactly one cycle; FSM -> RWAIT.
- RWAIT: on i_r_valid, i_r_data is latched and FSM -> TX. If i_r_valid and o_r_en coincide, the data is still accepted.
- TX:
  - o_tx_dv is high with o_tx_data = current byte.
  - On a cycle with i_tx_ready high, the next byte is presented in the following cycle; i_tx_ready low stalls with data held stable.
  - After DATA_BYTES accepted bytes, o_tx_dv drops and FSM -> IDLE.
  - If i_tx_ready is held high, one byte is sent per cycle.
- Bytes received in WPULSE, RREQ, RWAIT or TX are dropped and cause an o_err pulse; the transaction in progress continues unaffected.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on every i_dv and on entry to ADDR, WDATA or RWAIT; it counts only in those states.
  - Reaching TIMEOUT_CYCLES: o_err pulses, FSM -> IDLE, no o_w_en is issued, and partially shifted registers are discarded.
  - TX never times out.
- If i_dv arrives in the same cycle the timeout expires, the timeout wins and the byte is dropped.
- o_err pulses are one cycle each, with no accumulation.

Decomposition:
- Package command_controller_pkg holds:
  - the state enum typedef
  - CMD_WRITE = 8'h01 and CMD_READ = 8'h02
  - the localparam rule for the byte-counter width, $clog2(max(ADDR_BYTES, DATA_BYTES)+1)
- Sub-module cmd_timeout_timer: parameter TIMEOUT_CYCLES; inputs clk, i_reset, i_clear, i_run; output o_expired, a one-cycle pulse.

Test Plan:
- Write: bytes 01,12,01,23,34,56 with 10 idle cycles between each, PULSE_W_EN_LEN=3 -> o_w_addr=0x12, o_w_data=0x01233456, o_w_en high exactly 3 cycles starting the cycle after byte 0x56; no o_err.
- Read: bytes 02,34; respond i_r_valid with i_r_data=0xDEADBEEF two cycles after o_r_en; i_tx_ready toggling 1,0,1,1,1 -> o_r_addr=0x34, one o_r_en pulse, TX bytes DE,AD,BE,EF in order, each held while stalled; o_busy falls after EF.
- Unknown command: byte 0x7F in IDLE -> single o_err pulse, FSM stays IDLE, then a full valid write completes normally.
- Timeout: TIMEOUT_CYCLES=20; send 01,12,AA then silence -> o_err at the 20th idle cycle, no o_w_en, o_w_data unchanged; a subsequent write succeeds.
- Reset mid-write: reset asserted after the 2nd data byte -> all outputs 0 after the edge; a fresh write afterwards yields correct data.
- ADDR_BYTES=2, DATA_BYTES=2: bytes 01,AB,CD,12,34 -> o_w_addr=0xABCD, o_w_data=0x1234.

Source files
------------

// File: rtl/command_controller_pkg.sv
// Shared types and constants for the byte-stream register-bank command controller.
package command_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WPULSE,
        ST_RREQ,
        ST_RWAIT,
        ST_TX
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Byte counter must hold 0..max(ADDR_BYTES, DATA_BYTES).
    function automatic int cnt_width(input int addr_bytes, input int data_bytes);
        return $clog2(((addr_bytes > data_bytes) ? addr_bytes : data_bytes) + 1);
    endfunction

endpackage

// File: rtl/command_controller_rw_timer.sv
// Inter-byte timeout: a down-counter reloaded on clear, expiring when it
// would step past 1 while running.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!i_reset) begin
                    cnt_q <= '0;
                end else if (i_clear) begin
                    cnt_q <= CW'(TIMEOUT_CYCLES);
                end else if (i_run && cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            // Ignores i_clear so a byte landing on the expiry cycle loses to the timeout.
            assign o_expired = i_run && (cnt_q == CW'(1));
        end
    endgenerate

endmodule

// File: rtl/command_controller_rw.sv
// Parses a byte stream into register-bank writes and reads, and returns read
// data as a byte stream with valid/ready handshake.
//
//   state     | meaning
//   ST_IDLE   | waiting for a command byte
//   ST_ADDR   | shifting in ADDR_BYTES address bytes
//   ST_WDATA  | shifting in DATA_BYTES write-data bytes
//   ST_WPULSE | o_w_en held high for PULSE_W_EN_LEN cycles
//   ST_RREQ   | issuing the one-cycle read request
//   ST_RWAIT  | waiting for i_r_valid
//   ST_TX     | streaming read data out, MSB byte first
module command_controller_rw
    import command_controller_pkg::*;
#(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 4,
    parameter int PULSE_W_EN_LEN = 1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_data,
    input  logic                    i_dv,
    output logic [8*ADDR_BYTES-1:0] o_w_addr,
    output logic [8*DATA_BYTES-1:0] o_w_data,
    output logic                    o_w_en,
    output logic [8*ADDR_BYTES-1:0] o_r_addr,
    output logic                    o_r_en,
    input  logic [8*DATA_BYTES-1:0] i_r_data,
    input  logic                    i_r_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_dv,
    input  logic                    i_tx_ready,
    output logic                    o_err,
    output logic                    o_busy
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int DW    = 8 * DATA_BYTES;
    localparam int CNT_W = cnt_width(ADDR_BYTES, DATA_BYTES);
    localparam int PW    = $clog2(PULSE_W_EN_LEN + 1);

    state_t           state_q, state_d;
    logic             is_read_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [PW-1:0]    pulse_cnt_q;
    logic [AW-1:0]    addr_sr_q, addr_next;
    logic [DW-1:0]    data_sr_q, data_next;
    logic [DW-1:0]    rdata_q;

    logic start, addr_shift, data_shift, w_commit, r_req, r_latch, tx_adv;
    logic err_d, byte_last;
    logic expired, tmr_clear, tmr_run;

    assign addr_next = (addr_sr_q << 8) | AW'(i_data);
    assign data_next = (data_sr_q << 8) | DW'(i_data);
    assign byte_last = (state_q == ST_ADDR) ? (byte_cnt_q == CNT_W'(ADDR_BYTES - 1))
                                            : (byte_cnt_q == CNT_W'(DATA_BYTES - 1));

    assign tmr_run   = state_q inside {ST_ADDR, ST_WDATA, ST_RWAIT};
    assign tmr_clear = i_dv || ((state_d != state_q) && (state_d inside {ST_ADDR, ST_WDATA, ST_RWAIT}));

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clear  (tmr_clear),
        .i_run    (tmr_run),
        .o_expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!i_reset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        start      = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        w_commit   = 1'b0;
        r_req      = 1'b0;
        r_latch    = 1'b0;
        tx_adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_dv) begin
                    if (i_data == CMD_WRITE || i_data == CMD_READ) begin
                        start   = 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_dv) begin
                    addr_shift = 1'b1;
                    if (byte_last) state_d = is_read_q ? ST_RREQ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_dv) begin
                    data_shift = 1'b1;
                    if (byte_last) begin
                        w_commit = 1'b1;
                        state_d  = ST_WPULSE;
                    end
                end
            end
            ST_WPULSE: begin
                err_d = i_dv;
                if (pulse_cnt_q == '0) state_d = ST_IDLE;
            end
            ST_RREQ: begin
                err_d   = i_dv;
                r_req   = 1'b1;
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                err_d = i_dv;
                if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_r_valid) begin
                    r_latch = 1'b1;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                err_d = i_dv;
                if (i_tx_ready) begin
                    tx_adv = 1'b1;
                    if (byte_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            is_read_q   <= 1'b0;
            byte_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            addr_sr_q   <= '0;
            data_sr_q   <= '0;
            rdata_q     <= '0;
            o_w_addr    <= '0;
            o_w_data    <= '0;
            o_w_en      <= 1'b0;
            o_r_addr    <= '0;
            o_r_en      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            // A new command discards anything left over from an aborted one.
            if (start) begin
                is_read_q  <= (i_data == CMD_READ);
                byte_cnt_q <= '0;
                addr_sr_q  <= '0;
                data_sr_q  <= '0;
            end else if (addr_shift || data_shift || tx_adv) begin
                byte_cnt_q <= byte_last ? '0 : byte_cnt_q + 1'b1;
            end
            if (addr_shift) addr_sr_q <= addr_next;
            if (data_shift) data_sr_q <= data_next;

            if (w_commit) begin
                o_w_addr    <= addr_sr_q;
                o_w_data    <= data_next;
                pulse_cnt_q <= PW'(PULSE_W_EN_LEN - 1);
            end else if (state_q == ST_WPULSE && pulse_cnt_q != '0) begin
                pulse_cnt_q <= pulse_cnt_q - 1'b1;
            end
            o_w_en <= w_commit || (state_q == ST_WPULSE && pulse_cnt_q != '0);

            if (r_req) o_r_addr <= addr_sr_q;
            o_r_en <= r_req;

            if (r_latch)     rdata_q <= i_r_data;
            else if (tx_adv) rdata_q <= rdata_q << 8;

            o_err <= err_d;
        end
    end

    assign o_tx_data = rdata_q[DW-1 -: 8];
    assign o_tx_dv   = (state_q == ST_TX);
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_command_controller_rw.sv
// Directed bench: write, read with stalled TX, unknown command, timeout,
// mid-write reset, and a 2-byte address/data variant.
module tb_command_controller_rw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data;
    logic        dv;
    logic [31:0] r_data;
    logic        r_valid;
    logic        tx_ready;
    logic [7:0]  w_addr, r_addr, tx_data;
    logic [31:0] w_data;
    logic        w_en, r_en, tx_dv, err, busy;

    logic [7:0]  data2;
    logic        dv2;
    logic [15:0] w_addr2, w_data2, r_addr2;
    logic        w_en2, r_en2, tx_dv2, err2, busy2;
    logic [7:0]  tx_data2;

    int n_checks = 0;
    int n_errors = 0;
    int en_total = 0;
    int err_total = 0;
    int ren_total = 0;
    int first;
    int ncyc;
    int idx;
    logic        found;
    logic [4:0]  pat;
    logic [7:0]  exp_b [4];

    always #5 clk = ~clk;

    command_controller_rw #(
        .ADDR_BYTES(1), .DATA_BYTES(4), .PULSE_W_EN_LEN(3), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .i_reset(rst_n), .i_data(data), .i_dv(dv),
        .o_w_addr(w_addr), .o_w_data(w_data), .o_w_en(w_en),
        .o_r_addr(r_addr), .o_r_en(r_en), .i_r_data(r_data), .i_r_valid(r_valid),
        .o_tx_data(tx_data), .o_tx_dv(tx_dv), .i_tx_ready(tx_ready),
        .o_err(err), .o_busy(busy)
    );

    command_controller_rw #(
        .ADDR_BYTES(2), .DATA_BYTES(2), .PULSE_W_EN_LEN(1), .TIMEOUT_CYCLES(1000)
    ) dut2 (
        .clk(clk), .i_reset(rst_n), .i_data(data2), .i_dv(dv2),
        .o_w_addr(w_addr2), .o_w_data(w_data2), .o_w_en(w_en2),
        .o_r_addr(r_addr2), .o_r_en(r_en2), .i_r_data(16'h0), .i_r_valid(1'b0),
        .o_tx_data(tx_data2), .o_tx_dv(tx_dv2), .i_tx_ready(1'b0),
        .o_err(err2), .o_busy(busy2)
    );

    always @(negedge clk) begin
        if (w_en) en_total++;
        if (err)  err_total++;
        if (r_en) ren_total++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the cycle following the capture edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data = b;
        dv   = 1'b1;
        @(negedge clk);
        dv   = 1'b0;
        data = 8'h00;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        @(negedge clk);
        data2 = b;
        dv2   = 1'b1;
        @(negedge clk);
        dv2   = 1'b0;
        data2 = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; data = 8'h00; dv = 1'b0; r_data = 32'h0; r_valid = 1'b0;
        tx_ready = 1'b0; data2 = 8'h00; dv2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_w_en", w_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w_data", w_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write with 10 silent cycles between bytes
        send_byte(8'h01); repeat (9) @(negedge clk);
        send_byte(8'h12); repeat (9) @(negedge clk);
        send_byte(8'h01); repeat (9) @(negedge clk);
        send_byte(8'h23); repeat (9) @(negedge clk);
        send_byte(8'h34); repeat (9) @(negedge clk);
        chk("w1_en_before", w_en, 0);
        send_byte(8'h56);
        chk("w1_addr", w_addr, 64'h12);
        chk("w1_data", w_data, 64'h01233456);
        first = -1; ncyc = 0;
        for (int k = 0; k < 6; k++) begin
            if (w_en) begin
                if (first < 0) first = k;
                ncyc++;
            end
            @(negedge clk);
        end
        chk("w1_en_start", first, 0);
        chk("w1_en_len", ncyc, 3);
        chk("w1_no_err", err_total, 0);

        // Unknown command, then a back-to-back write
        send_byte(8'h7F);
        chk("unk_err", err, 1);
        chk("unk_busy", busy, 0);
        @(negedge clk);
        chk("unk_err_once", err, 0);
        send_byte(8'h01); send_byte(8'h5A);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("w2_addr", w_addr, 64'h5A);
        chk("w2_data", w_data, 64'h11223344);
        repeat (5) @(negedge clk);

        // Read with stalled transmitter
        send_byte(8'h02); send_byte(8'h34);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (r_en) found = 1'b1;
            else @(negedge clk);
        end
        chk("rd_r_en_seen", found, 1);
        chk("rd_addr", r_addr, 64'h34);
        repeat (2) @(negedge clk);
        r_data = 32'hDEADBEEF; r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        pat = 5'b11101;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            chk("tx_dv", tx_dv, 1);
            chk("tx_data", tx_data, exp_b[idx]);
            chk("tx_busy", busy, 1);
            tx_ready = pat[i];
            @(negedge clk);
            if (pat[i]) idx++;
        end
        tx_ready = 1'b0;
        chk("tx_dv_done", tx_dv, 0);
        chk("tx_busy_done", busy, 0);
        repeat (3) @(negedge clk);

        // Timeout: expiry is registered at the edge closing the 20th silent
        // cycle after 0xAA, so o_err is observed in the cycle after that edge.
        send_byte(8'h01); send_byte(8'h12); send_byte(8'hAA);
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            if (err && first < 0) first = k;
            @(negedge clk);
        end
        chk("to_err_cycle", first, 21);
        chk("to_busy", busy, 0);
        chk("to_w_data_kept", w_data, 64'h11223344);
        chk("to_no_w_en", en_total, 6);
        send_byte(8'h01); send_byte(8'h77);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        chk("w3_addr", w_addr, 64'h77);
        chk("w3_data", w_data, 64'hA1B2C3D4);
        repeat (5) @(negedge clk);

        // Reset after the second data byte
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h01); send_byte(8'h23);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_w_addr", w_addr, 0);
        chk("mr_w_data", w_data, 0);
        chk("mr_w_en", w_en, 0);
        chk("mr_r_addr", r_addr, 0);
        chk("mr_r_en", r_en, 0);
        chk("mr_tx_dv", tx_dv, 0);
        chk("mr_tx_data", tx_data, 0);
        chk("mr_err", err, 0);
        chk("mr_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h01); send_byte(8'h34);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        chk("w4_addr", w_addr, 64'h34);
        chk("w4_data", w_data, 64'hCAFEBABE);
        repeat (5) @(negedge clk);

        // Two-byte address and data
        send_byte2(8'h01); send_byte2(8'hAB); send_byte2(8'hCD);
        send_byte2(8'h12); send_byte2(8'h34);
        chk("d2_addr", w_addr2, 64'hABCD);
        chk("d2_data", w_data2, 64'h1234);
        chk("d2_en", w_en2, 1);
        @(negedge clk);
        chk("d2_en_off", w_en2, 0);
        chk("d2_err", err2, 0);

        repeat (3) @(negedge clk);
        chk("tot_w_en_cycles", en_total, 12);
        chk("tot_err_pulses", err_total, 2);
        chk("tot_r_en_pulses", ren_total, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
